// File: rtl/ram_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ram_port_arbiter
// Brief    : Two-requester round-robin arbiter and sequencer in front of a
//            single-port synchronous RAM (write on edge, registered read
//            address). Each grant carries one read or one write; read data
//            returns on a separate rvalid pulse.
// Options  : RAM_ARB_STATS_EN adds saturating 16-bit grant counters
//            (gnt_cnt0 / gnt_cnt1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ram_port_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // requester 0
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   // requester 1
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   // RAM side
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q,
   // status
   output logic              busy
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [15:0]       gnt_cnt0,
   output logic [15:0]       gnt_cnt1
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RDATA  = 2'd2
   } state_t;

   state_t              state_q,      state_d;
   logic                last_owner_q, last_owner_d;
   logic                gnt0_q,       gnt0_d;
   logic                gnt1_q,       gnt1_d;
   logic                rvalid0_q,    rvalid0_d;
   logic                rvalid1_q,    rvalid1_d;
   logic [DATA_W-1:0]   rdata0_q,     rdata0_d;
   logic [DATA_W-1:0]   rdata1_q,     rdata1_d;
   logic [ADDR_W-1:0]   ram_addr_q,   ram_addr_d;
   logic [DATA_W-1:0]   ram_data_q,   ram_data_d;
   logic                ram_we_q,     ram_we_d;
   logic                busy_q,       busy_d;
   logic                owner_sel;

   // Next-state, arbitration and registered-output computation
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      rvalid0_d    = 1'b0;
      rvalid1_d    = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      ram_addr_d   = ram_addr_q;
      ram_data_d   = ram_data_q;
      ram_we_d     = 1'b0;
      // Under contention the requester that did not own the last access wins;
      // otherwise whichever single requester is asking.
      owner_sel    = (req0 && req1) ? ~last_owner_q : req1;

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               last_owner_d = owner_sel;
               if (owner_sel) begin
                  gnt1_d     = 1'b1;
                  ram_we_d   = we1;
                  ram_addr_d = addr1;
                  ram_data_d = wdata1;
               end else begin
                  gnt0_d     = 1'b1;
                  ram_we_d   = we0;
                  ram_addr_d = addr0;
                  ram_data_d = wdata0;
               end
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // A write completes at this edge; a read only registers its address.
            state_d = ram_we_q ? S_IDLE : S_RDATA;
         end
         S_RDATA: begin
            // ram_q reflects the address registered at the end of ACCESS.
            if (last_owner_q) begin
               rdata1_d  = ram_q;
               rvalid1_d = 1'b1;
            end else begin
               rdata0_d  = ram_q;
               rvalid0_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset acts immediately, independent of clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_owner_q <= 1'b1;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
         ram_we_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
         ram_we_q     <= ram_we_d;
         busy_q       <= busy_d;
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign ram_we   = ram_we_q;
   assign busy     = busy_q;

`ifdef RAM_ARB_STATS_EN
   logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
   logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

   // Saturating grant counters, bumped on the same edge that raises gnt
   always_comb begin
      gnt_cnt0_d = gnt_cnt0_q;
      gnt_cnt1_d = gnt_cnt1_q;
      if (gnt0_d && (gnt_cnt0_q != 16'hFFFF)) begin
         gnt_cnt0_d = gnt_cnt0_q + 16'd1;
      end
      if (gnt1_d && (gnt_cnt1_q != 16'hFFFF)) begin
         gnt_cnt1_d = gnt_cnt1_q + 16'd1;
      end
   end

   // Grant counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
      end else begin
         gnt_cnt0_q <= gnt_cnt0_d;
         gnt_cnt1_q <= gnt_cnt1_d;
      end
   end

   assign gnt_cnt0 = gnt_cnt0_q;
   assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ram_port_arbiter
// Brief    : Self-checking bench for ram_port_arbiter: directed vector table,
//            multi-cycle corner sequences and a randomized phase checked
//            against a transaction-level reference model. Includes a
//            behavioural 64x8 RAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ram_port_arbiter;

   localparam int RN = 400;   // randomized cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [5:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
   logic [7:0] rdata0, rdata1, ram_data, ram_q;
   logic [5:0] ram_addr;
`ifdef RAM_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
      .ram_q(ram_q), .busy(busy)
`ifdef RAM_ARB_STATS_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
   );

   // Behavioural RAM: unwritten words read as 8'hC0 | address
   logic [7:0]  mem [0:63];
   logic [63:0] written = '0;
   logic [5:0]  ram_addr_r = '0;

   function automatic logic [7:0] init_val(input logic [5:0] a);
      return 8'hC0 | {2'b00, a};
   endfunction

   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr]     <= ram_data;
         written[ram_addr] <= 1'b1;
      end else begin
         ram_addr_r <= ram_addr;
      end
   end
   assign ram_q = written[ram_addr_r] ? mem[ram_addr_r] : init_val(ram_addr_r);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_gnt",    32'({gnt0, gnt1}), 32'd0);
      chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
      chk("rst_rdata",  32'({rdata0, rdata1}), 32'd0);
      chk("rst_ram",    32'({ram_we, ram_addr, ram_data}), 32'd0);
      chk("rst_busy",   32'(busy), 32'd0);
      rst_n = 1'b1;
   endtask

   // Single read through an idle arbiter, bounded waits
   task automatic do_read(input int who, input logic [5:0] a, input logic [7:0] exp);
      bit seen;
      if (who == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = a; end
      else          begin req1 = 1'b1; we1 = 1'b0; addr1 = a; end
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         @(negedge clk);
         if ((who == 0 && gnt0) || (who == 1 && gnt1)) seen = 1;
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("rd_gnt_seen", 32'(seen), 32'd1);
      seen = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         @(negedge clk);
         if ((who == 0 && rvalid0) || (who == 1 && rvalid1)) seen = 1;
      end
      chk("rd_rvalid_seen", 32'(seen), 32'd1);
      chk("rd_data", 32'((who == 0) ? rdata0 : rdata1), 32'(exp));
   endtask

   typedef struct {
      logic       r0, w0; logic [5:0] a0; logic [7:0] d0;
      logic       r1, w1; logic [5:0] a1; logic [7:0] d1;
      logic       own;    logic [7:0] rd;
   } vec_t;

   vec_t vec [0:8];

   task automatic run_table();
      logic       ew;
      logic [5:0] ea;
      logic [7:0] ed;
      vec[0] = '{1'b1, 1'b1, 6'h05, 8'hA5, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 8'h00};
      vec[1] = '{1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h05, 8'h00, 1'b1, 8'hA5};
      vec[2] = '{1'b1, 1'b0, 6'h01, 8'h77, 1'b1, 1'b1, 6'h3C, 8'h10, 1'b0, 8'hC1};
      vec[3] = '{1'b1, 1'b0, 6'h01, 8'h77, 1'b1, 1'b1, 6'h3C, 8'h10, 1'b1, 8'h00};
      vec[4] = '{1'b1, 1'b1, 6'h3F, 8'h13, 1'b1, 1'b0, 6'h3C, 8'h00, 1'b0, 8'h00};
      vec[5] = '{1'b1, 1'b1, 6'h3F, 8'h13, 1'b1, 1'b0, 6'h3C, 8'h00, 1'b1, 8'h10};
      vec[6] = '{1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h3F, 8'h00, 1'b1, 8'h13};
      vec[7] = '{1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b1, 6'h00, 8'h99, 1'b1, 8'h00};
      vec[8] = '{1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h3F, 8'h00, 1'b0, 8'h99};
      for (int i = 0; i < 9; i++) begin
         req0 = vec[i].r0; we0 = vec[i].w0; addr0 = vec[i].a0; wdata0 = vec[i].d0;
         req1 = vec[i].r1; we1 = vec[i].w1; addr1 = vec[i].a1; wdata1 = vec[i].d1;
         ew = vec[i].own ? vec[i].w1 : vec[i].w0;
         ea = vec[i].own ? vec[i].a1 : vec[i].a0;
         ed = vec[i].own ? vec[i].d1 : vec[i].d0;
         @(posedge clk);
         @(negedge clk);
         chk("tbl_gnt",      32'({gnt0, gnt1}), 32'({~vec[i].own, vec[i].own}));
         chk("tbl_ram_we",   32'(ram_we), 32'(ew));
         chk("tbl_ram_addr", 32'(ram_addr), 32'(ea));
         chk("tbl_ram_data", 32'(ram_data), 32'(ed));
         chk("tbl_busy",     32'(busy), 32'd1);
         req0 = 1'b0; req1 = 1'b0;
         @(negedge clk);
         chk("tbl_gnt_pulse", 32'({gnt0, gnt1, ram_we}), 32'd0);
         if (!ew) begin
            chk("tbl_rdata_busy", 32'({busy, rvalid0, rvalid1}), 32'b100);
            @(negedge clk);
            chk("tbl_rvalid", 32'({rvalid0, rvalid1}), 32'({~vec[i].own, vec[i].own}));
            chk("tbl_rdata",  32'(vec[i].own ? rdata1 : rdata0), 32'(vec[i].rd));
         end
         chk("tbl_idle", 32'(busy), 32'd0);
      end
   endtask

   // Transaction-level reference model for the random phase
   typedef struct { logic g0, g1, we, busy, rv0, rv1; logic [7:0] rd; } cyc_t;
   cyc_t       exp_c [0:RN+3];
   logic [7:0] shadow [0:63];

   task automatic rand_cmd(input int who);
      logic       r, w;
      logic [5:0] a;
      logic [7:0] d;
      r = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 1) != 0);
      a = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      d = 8'($urandom);
      if (who == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else          begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic run_random();
      logic       last_own, own, cw;
      logic [5:0] ca, cur_a;
      logic [7:0] cd, cur_d, cur_r0, cur_r1;
      int         next_sample, n_g0, n_g1;
      bit         granted;
      apply_reset();
      for (int i = 0; i < 64; i++) shadow[i] = written[i] ? mem[i] : init_val(6'(i));
      for (int i = 0; i <= RN + 3; i++) exp_c[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      last_own = 1'b1; own = 1'b0; next_sample = 1; n_g0 = 0; n_g1 = 0;
      cur_a = '0; cur_d = '0; cur_r0 = '0; cur_r1 = '0;
      rand_cmd(0); rand_cmd(1);
      for (int e = 1; e <= RN; e++) begin
         @(posedge clk);
         granted = 0;
         if (e >= next_sample && (req0 || req1)) begin
            own = (req0 && req1) ? ~last_own : req1;
            last_own = own;
            granted = 1;
            cw = own ? we1 : we0;
            ca = own ? addr1 : addr0;
            cd = own ? wdata1 : wdata0;
            cur_a = ca; cur_d = cd;
            if (own) begin exp_c[e].g1 = 1'b1; n_g1++; end
            else     begin exp_c[e].g0 = 1'b1; n_g0++; end
            exp_c[e].busy = 1'b1;
            if (cw) begin
               exp_c[e].we = 1'b1;
               shadow[ca]  = cd;
               next_sample = e + 2;
            end else begin
               exp_c[e+1].busy = 1'b1;
               if (own) exp_c[e+2].rv1 = 1'b1; else exp_c[e+2].rv0 = 1'b1;
               exp_c[e+2].rd = shadow[ca];
               next_sample = e + 3;
            end
         end
         @(negedge clk);
         if (exp_c[e].rv0) cur_r0 = exp_c[e].rd;
         if (exp_c[e].rv1) cur_r1 = exp_c[e].rd;
         chk("rnd_gnt0",    32'(gnt0),    32'(exp_c[e].g0));
         chk("rnd_gnt1",    32'(gnt1),    32'(exp_c[e].g1));
         chk("rnd_ram_we",  32'(ram_we),  32'(exp_c[e].we));
         chk("rnd_busy",    32'(busy),    32'(exp_c[e].busy));
         chk("rnd_rvalid0", 32'(rvalid0), 32'(exp_c[e].rv0));
         chk("rnd_rvalid1", 32'(rvalid1), 32'(exp_c[e].rv1));
         chk("rnd_rdata0",  32'(rdata0),  32'(cur_r0));
         chk("rnd_rdata1",  32'(rdata1),  32'(cur_r1));
         chk("rnd_ram_addr", 32'(ram_addr), 32'(cur_a));
         chk("rnd_ram_data", 32'(ram_data), 32'(cur_d));
         if (granted) rand_cmd(own ? 1 : 0);
         if (!req0 && $urandom_range(0, 1) == 1) rand_cmd(0);
         if (!req1 && $urandom_range(0, 1) == 1) rand_cmd(1);
      end
`ifdef RAM_ARB_STATS_EN
      chk("stat_cnt0", 32'(gnt_cnt0), 32'(n_g0));
      chk("stat_cnt1", 32'(gnt_cnt1), 32'(n_g1));
`endif
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_g, n_g;
      int gord [0:7];
      bit seen;

      // Reset state, then the directed vector table
      @(negedge clk);
      apply_reset();
      run_table();

      // Four back-to-back writes from requester 1 only
      req1 = 1'b1; we1 = 1'b1; addr1 = 6'h3C; wdata1 = 8'h10;
      n_g = 0; last_g = -10;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (gnt1) begin
            if (n_g > 0) chk("b2b_spacing", 32'(c - last_g), 32'd2);
            chk("b2b_we", 32'({ram_we, ram_addr, ram_data}), 32'({1'b1, addr1, wdata1}));
            last_g = c;
            n_g++;
            if (n_g < 4) begin addr1 = addr1 + 6'd1; wdata1 = wdata1 + 8'd1; end
            else req1 = 1'b0;
         end
      end
      req1 = 1'b0;
      chk("b2b_count", 32'(n_g), 32'd4);
      @(negedge clk);
      for (int i = 0; i < 4; i++) do_read(0, 6'(6'h3C + i), 8'(8'h10 + i));

      // Continuous contention from reset, both reading
      apply_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 6'h00;
      req1 = 1'b1; we1 = 1'b0; addr1 = 6'h01;
      n_g = 0; last_g = -10;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk("cont_no_overlap", 32'(gnt0 & gnt1), 32'd0);
         if (gnt0 || gnt1) begin
            if (n_g < 8) gord[n_g] = gnt1 ? 1 : 0;
            if (n_g > 0) chk("cont_spacing", 32'(c - last_g), 32'd3);
            chk("cont_busy", 32'(busy), 32'd1);
            last_g = c;
            n_g++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("cont_count", 32'(n_g), 32'd4);
      for (int i = 0; i < 4 && i < n_g; i++) chk("cont_order", 32'(gord[i]), 32'(i % 2));
      chk("cont_rdata0", 32'(rdata0), 32'h99);
      chk("cont_rdata1", 32'(rdata1), 32'hC1);

      // Reset during the ACCESS cycle of a write
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 6'h20; wdata0 = 8'hFF;
      @(posedge clk);
      #2;
      chk("mid_acc_we_before", 32'(ram_we), 32'd1);
      rst_n = 1'b0;
      req0 = 1'b0;
      #1;
      chk("mid_acc_we_drop", 32'(ram_we), 32'd0);
      chk("mid_acc_idle",    32'({busy, gnt0}), 32'd0);
      @(negedge clk);
      apply_reset();
      do_read(0, 6'h20, 8'hE0);

      // Reset during RDATA: no rvalid, rdata stays at reset value
      apply_reset();
      req1 = 1'b1; we1 = 1'b0; addr1 = 6'h3C;
      @(posedge clk);
      @(negedge clk);
      req1 = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rvalid1 || rdata1 != 8'h00) seen = 1;
      end
      chk("mid_rdata_no_rvalid", 32'(seen), 32'd0);
      apply_reset();

      // Randomized phase against the reference model
      run_random();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
